// File: rtl/ysyx_22041207_axi_rd_arbiter_if.sv
// Read-channel bundle: request (valid/ready/addr/size) plus data (valid/ready/data).
// Purely structural, no latency of its own.
// Backpressure is carried by r_ready_o on requests and r_data_ready on data.
interface ysyx_22041207_axi_rd_arbiter_if #(
    parameter int DW = 64,
    parameter int AW = 64
);
    logic          r_valid_i;
    logic          r_ready_o;
    logic [AW-1:0] r_addr_i;
    logic [7:0]    r_size_i;
    logic          r_data_valid;
    logic          r_data_ready;
    logic [DW-1:0] data_read_o;

    // Side that issues requests and consumes data.
    modport master (
        output r_valid_i, r_addr_i, r_size_i, r_data_ready,
        input  r_ready_o, r_data_valid, data_read_o
    );

    // Side that accepts requests and returns data.
    modport slave (
        input  r_valid_i, r_addr_i, r_size_i, r_data_ready,
        output r_ready_o, r_data_valid, data_read_o
    );
endinterface

// File: rtl/ysyx_22041207_axi_rd_arbiter.sv
// Shares one downstream read slave between MEM (priority) and IF, with IF anti-starvation.
// Grant in IDLE is combinational (ready pulse same cycle); address phase starts next cycle; >=3 cycles per txn.
// One transaction at a time: slave ready stalls ADDR, owner data_ready stalls DATA; requests wait in IDLE.
module ysyx_22041207_axi_rd_arbiter #(
    parameter int RW_DATA_WIDTH = 64,
    parameter int RW_ADDR_WIDTH = 64,
    parameter int STARVE_LIMIT  = 4,
    parameter int CNT_WIDTH     = 3
) (
    input  logic clk,
    input  logic rst,
    ysyx_22041207_axi_rd_arbiter_if.slave  mem,
    ysyx_22041207_axi_rd_arbiter_if.slave  ifu,
    ysyx_22041207_axi_rd_arbiter_if.master s,
    output logic busy_o,
    output logic grant_mem_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    state_e                     state_q, state_d;
    logic [RW_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                 size_q, size_d;
    logic                       grant_q, grant_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;

    logic                       both_vld;
    logic                       mem_win;
    logic                       if_win;
    logic                       in_addr;
    logic                       in_data;
    logic                       data_rdy;
    logic [RW_DATA_WIDTH-1:0]   s_data;

    assign both_vld = mem.r_valid_i & ifu.r_valid_i;
    assign in_addr  = (state_q == ADDR);
    assign in_data  = (state_q == DATA);
    assign s_data   = s.data_read_o;

    // Forward the owner's consumer ready to the slave only while in the data phase.
    assign data_rdy = in_data & (grant_q ? mem.r_data_ready : ifu.r_data_ready);

    // Arbitration, capture of the winning request and FSM next-state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        mem_win = 1'b0;
        if_win  = 1'b0;
        case (state_q)
            IDLE: begin
                if (both_vld) begin
                    // IF takes the slot once it has lost LIMIT contested rounds in a row.
                    if (cnt_q == LIMIT) begin
                        if_win = 1'b1;
                    end else begin
                        mem_win = 1'b1;
                    end
                end else if (mem.r_valid_i) begin
                    mem_win = 1'b1;
                end else if (ifu.r_valid_i) begin
                    if_win = 1'b1;
                end

                if (mem_win) begin
                    state_d = ADDR;
                    addr_d  = mem.r_addr_i;
                    size_d  = mem.r_size_i;
                    grant_d = 1'b1;
                end else if (if_win) begin
                    state_d = ADDR;
                    addr_d  = ifu.r_addr_i;
                    size_d  = ifu.r_size_i;
                    grant_d = 1'b0;
                end

                // Only a contested MEM win counts as an IF loss; any IF grant clears the history.
                if (if_win) begin
                    cnt_d = '0;
                end else if (both_vld && (cnt_q != LIMIT)) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ADDR: begin
                if (s.r_ready_o) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (s.r_data_valid && data_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and starvation history; reset discards any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            grant_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request acceptance pulses; gated by reset so nothing is granted while it is held.
    assign mem.r_ready_o = mem_win & ~rst;
    assign ifu.r_ready_o = if_win & ~rst;

    // Slave address phase driven from the latched request only.
    assign s.r_valid_i    = in_addr;
    assign s.r_addr_i     = in_addr ? addr_q : '0;
    assign s.r_size_i     = in_addr ? size_q : '0;
    assign s.r_data_ready = data_rdy;

    // Data returned to the owner only; the other requester sees zeros.
    assign mem.r_data_valid = in_data & grant_q & s.r_data_valid;
    assign ifu.r_data_valid = in_data & ~grant_q & s.r_data_valid;
    assign mem.data_read_o  = (in_data & grant_q) ? s_data : '0;
    assign ifu.data_read_o  = (in_data & ~grant_q) ? s_data : '0;

    assign busy_o      = (state_q != IDLE);
    assign grant_mem_o = grant_q;

endmodule

// File: tb/tb_ysyx_22041207_axi_rd_arbiter.sv
module tb_ysyx_22041207_axi_rd_arbiter;

    logic clk;
    logic rst;
    logic busy;
    logic grant_mem;

    int checks = 0;
    int errors = 0;

    ysyx_22041207_axi_rd_arbiter_if #(.DW(64), .AW(64)) mem_bus ();
    ysyx_22041207_axi_rd_arbiter_if #(.DW(64), .AW(64)) if_bus ();
    ysyx_22041207_axi_rd_arbiter_if #(.DW(64), .AW(64)) s_bus ();

    ysyx_22041207_axi_rd_arbiter #(
        .RW_DATA_WIDTH(64),
        .RW_ADDR_WIDTH(64),
        .STARVE_LIMIT (4),
        .CNT_WIDTH    (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (mem_bus),
        .ifu        (if_bus),
        .s          (s_bus),
        .busy_o     (busy),
        .grant_mem_o(grant_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with immediate slave responses; requester valids left as the caller set them.
    task automatic run_txn(input logic exp_mem, input logic [63:0] exp_addr,
                           input logic [7:0] exp_size, input logic [63:0] data, input string tag);
        #1;
        chk({tag, "_mem_rdy"}, mem_bus.r_ready_o, exp_mem);
        chk({tag, "_if_rdy"}, if_bus.r_ready_o, !exp_mem);
        cyc();
        s_bus.r_ready_o = 1'b1;
        #1;
        chk({tag, "_s_vld"}, s_bus.r_valid_i, 1);
        chk({tag, "_s_addr"}, s_bus.r_addr_i, exp_addr);
        chk({tag, "_s_size"}, s_bus.r_size_i, exp_size);
        chk({tag, "_grant"}, grant_mem, exp_mem);
        chk({tag, "_rdy_quiet"}, {mem_bus.r_ready_o, if_bus.r_ready_o}, 0);
        cyc();
        s_bus.r_ready_o      = 1'b0;
        s_bus.r_data_valid   = 1'b1;
        s_bus.data_read_o    = data;
        mem_bus.r_data_ready = 1'b1;
        if_bus.r_data_ready  = 1'b1;
        #1;
        chk({tag, "_mem_dv"}, mem_bus.r_data_valid, exp_mem);
        chk({tag, "_if_dv"}, if_bus.r_data_valid, !exp_mem);
        chk({tag, "_mem_dat"}, mem_bus.data_read_o, exp_mem ? data : 64'd0);
        chk({tag, "_if_dat"}, if_bus.data_read_o, exp_mem ? 64'd0 : data);
        chk({tag, "_s_addr_off"}, s_bus.r_addr_i, 0);
        cyc();
        s_bus.r_data_valid   = 1'b0;
        s_bus.data_read_o    = '0;
        mem_bus.r_data_ready = 1'b0;
        if_bus.r_data_ready  = 1'b0;
    endtask

    initial begin
        rst                  = 1'b1;
        mem_bus.r_valid_i    = 1'b1;
        mem_bus.r_addr_i     = 64'h100;
        mem_bus.r_size_i     = 8'd8;
        mem_bus.r_data_ready = 1'b0;
        if_bus.r_valid_i     = 1'b0;
        if_bus.r_addr_i      = 64'h8000_0000;
        if_bus.r_size_i      = 8'd4;
        if_bus.r_data_ready  = 1'b0;
        s_bus.r_ready_o      = 1'b0;
        s_bus.r_data_valid   = 1'b0;
        s_bus.data_read_o    = '0;

        // Reset state, with a request pending that must not be granted.
        cyc();
        cyc();
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_mem, 0);
        chk("rst_mem_rdy", mem_bus.r_ready_o, 0);
        chk("rst_s_vld", s_bus.r_valid_i, 0);
        chk("rst_s_addr", s_bus.r_addr_i, 0);
        rst               = 1'b0;
        mem_bus.r_valid_i = 1'b0;

        // 1: IF alone; valid dropped right after acceptance.
        if_bus.r_valid_i = 1'b1;
        #1;
        chk("t1_if_rdy", if_bus.r_ready_o, 1);
        chk("t1_mem_rdy", mem_bus.r_ready_o, 0);
        chk("t1_busy_idle", busy, 0);
        cyc();
        if_bus.r_valid_i = 1'b0;
        s_bus.r_ready_o  = 1'b1;
        #1;
        chk("t1_s_vld", s_bus.r_valid_i, 1);
        chk("t1_s_addr", s_bus.r_addr_i, 64'h8000_0000);
        chk("t1_s_size", s_bus.r_size_i, 4);
        chk("t1_busy", busy, 1);
        chk("t1_grant", grant_mem, 0);
        cyc();
        s_bus.r_ready_o     = 1'b0;
        s_bus.r_data_valid  = 1'b1;
        s_bus.data_read_o   = 64'hDEAD_BEEF;
        if_bus.r_data_ready = 1'b1;
        #1;
        chk("t1_if_dat", if_bus.data_read_o, 64'hDEAD_BEEF);
        chk("t1_if_dv", if_bus.r_data_valid, 1);
        chk("t1_mem_dat", mem_bus.data_read_o, 0);
        chk("t1_mem_dv", mem_bus.r_data_valid, 0);
        chk("t1_s_drdy", s_bus.r_data_ready, 1);
        cyc();
        s_bus.r_data_valid  = 1'b0;
        s_bus.data_read_o   = '0;
        if_bus.r_data_ready = 1'b0;
        chk("t1_back_idle", busy, 0);

        // 2: both valid with empty starvation history -> MEM.
        mem_bus.r_valid_i = 1'b1;
        if_bus.r_valid_i  = 1'b1;
        run_txn(1'b1, 64'h100, 8'd8, 64'h1111, "t2");

        // 3: both held; with t2 counted, IF wins on the 5th and 10th contested rounds.
        for (int i = 0; i < 9; i++) begin
            if ((i == 3) || (i == 8)) begin
                run_txn(1'b0, 64'h8000_0000, 8'd4, 64'h2000 + 64'(i), $sformatf("t3_%0d", i));
            end else begin
                run_txn(1'b1, 64'h100, 8'd8, 64'h3000 + 64'(i), $sformatf("t3_%0d", i));
            end
        end
        if_bus.r_valid_i = 1'b0;

        // 4: slave stalls the address phase for 5 cycles.
        mem_bus.r_addr_i = 64'h1000;
        mem_bus.r_size_i = 8'd2;
        #1;
        chk("t4_mem_rdy", mem_bus.r_ready_o, 1);
        cyc();
        mem_bus.r_valid_i = 1'b0;
        mem_bus.r_addr_i  = 64'hFFFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t4_s_vld_%0d", i), s_bus.r_valid_i, 1);
            chk($sformatf("t4_s_addr_%0d", i), s_bus.r_addr_i, 64'h1000);
            chk($sformatf("t4_busy_%0d", i), busy, 1);
            cyc();
        end
        chk("t4_still_addr", s_bus.r_valid_i, 1);
        s_bus.r_ready_o = 1'b1;
        cyc();
        s_bus.r_ready_o = 1'b0;

        // 5: data valid while owner not ready; a pending IF request must wait.
        s_bus.r_data_valid   = 1'b1;
        s_bus.data_read_o    = 64'hCAFE;
        mem_bus.r_data_ready = 1'b0;
        if_bus.r_valid_i     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t5_busy_%0d", i), busy, 1);
            chk($sformatf("t5_s_drdy_%0d", i), s_bus.r_data_ready, 0);
            chk($sformatf("t5_if_rdy_%0d", i), if_bus.r_ready_o, 0);
            chk($sformatf("t5_mem_dat_%0d", i), mem_bus.data_read_o, 64'hCAFE);
            cyc();
        end
        mem_bus.r_data_ready = 1'b1;
        #1;
        chk("t5_s_drdy", s_bus.r_data_ready, 1);
        cyc();
        s_bus.r_data_valid   = 1'b0;
        mem_bus.r_data_ready = 1'b0;
        chk("t5_idle", busy, 0);
        chk("t5_if_rdy_after", if_bus.r_ready_o, 1);

        // 6: reset asserted in the middle of the IF data phase.
        cyc();
        if_bus.r_valid_i = 1'b0;
        s_bus.r_ready_o  = 1'b1;
        cyc();
        s_bus.r_ready_o     = 1'b0;
        s_bus.r_data_valid  = 1'b1;
        s_bus.data_read_o   = 64'h5555;
        if_bus.r_data_ready = 1'b0;
        #1;
        chk("t6_in_data", if_bus.r_data_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_if_dv", if_bus.r_data_valid, 0);
        chk("t6_if_dat", if_bus.data_read_o, 0);
        chk("t6_s_drdy", s_bus.r_data_ready, 0);
        chk("t6_s_vld", s_bus.r_valid_i, 0);
        cyc();
        rst                = 1'b0;
        s_bus.r_data_valid = 1'b0;
        s_bus.data_read_o  = '0;
        mem_bus.r_valid_i  = 1'b1;
        mem_bus.r_addr_i   = 64'h2000;
        mem_bus.r_size_i   = 8'd8;
        run_txn(1'b1, 64'h2000, 8'd8, 64'h7777, "t6_post");
        mem_bus.r_valid_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
